// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle core: word/byte RAM with
// combinational reads, plus an MMIO window holding a status register,
// an 8-bit transmit FIFO and a free-running cycle counter.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  input  logic        byte_enable,
  output logic [31:0] readdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] A_STATUS = 32'hFFFF_0000;
  localparam logic [31:0] A_TX     = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;

  logic [31:0]   ram  [DEPTH_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [31:0]   cyc;

  logic          is_mmio;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          full, empty;
  logic          push_req, push_acc, pop, ram_we, ovf_clr;
  logic [3:0]    cnt4;
  logic [31:0]   status;
  logic [31:0]   word;

  // Upper bits above the RAM index are ignored, so RAM addresses alias.
  assign is_mmio  = (aluout[31:16] == 16'hFFFF);
  assign widx     = aluout[AW+1:2];
  assign lane     = aluout[1:0];

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign out_valid = !empty;
  assign out_data  = fifo[rptr];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop      = out_valid && out_ready;
  assign push_req = memwrite && (aluout == A_TX);
  assign push_acc = push_req && (!full || pop);
  assign ovf_clr  = memwrite && (aluout == A_STATUS);
  assign ram_we   = memwrite && !is_mmio;

  assign cnt4     = 4'(count);
  assign status   = {24'd0, ovf, 1'b0, cnt4, empty, full};

  // Zero-latency load path: RAM word/byte or MMIO register.
  always_comb begin
    word     = ram[widx];
    readdata = '0;
    if (is_mmio) begin
      case (aluout)
        A_STATUS: readdata = status;
        A_CYCLE:  readdata = cyc;
        default:  readdata = '0;
      endcase
    end else if (byte_enable) begin
      readdata = {24'd0, word[{lane, 3'b000} +: 8]};
    end else begin
      readdata = word;
    end
  end

  // RAM, FIFO control, overflow flag and cycle counter; reset wins over stores/pops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) ram[i] <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      cyc   <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (ram_we) begin
        if (byte_enable) ram[widx][{lane, 3'b000} +: 8] <= writedata[7:0];
        else             ram[widx] <= writedata;
      end
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop)      rptr <= rptr + 1'b1;
      count <= count + CW'(push_acc) - CW'(pop);
      if (ovf_clr)                    ovf <= 1'b0;
      else if (push_req && !push_acc) ovf <= 1'b1;
    end
  end

  // FIFO storage needs no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (reset && push_acc) fifo[wptr] <= writedata[7:0];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// RAM/FIFO traffic compared against a byte-array / queue reference model.
module tb_dmem_responder;
  localparam int DW = 64;
  localparam int FD = 4;
  localparam int NB = DW * 4;

  logic        clk = 1'b0;
  logic        reset, memwrite, byte_enable, out_ready, out_valid;
  logic [31:0] aluout, writedata, readdata;
  logic [7:0]  out_data;

  logic [7:0]  m_mem [NB];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic [31:0] m_cyc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .byte_enable(byte_enable), .readdata(readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Reference load value from the model state.
  function automatic logic [31:0] m_read(input logic [31:0] a, input logic be);
    int base;
    if (a[31:16] == 16'hFFFF) begin
      case (a)
        32'hFFFF_0000: return {24'd0, m_ovf, 1'b0, 4'(m_q.size()),
                               m_q.size() == 0, m_q.size() == FD};
        32'hFFFF_0008: return m_cyc;
        default:       return 32'd0;
      endcase
    end
    base = int'(a & 32'(NB - 1));
    if (be) return {24'd0, m_mem[base]};
    base = base & ~3;
    return {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
  endfunction

  // Apply one clock edge to the model from the current inputs, then to the DUT.
  task automatic step();
    bit p;
    int n, base;
    if (!reset) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'd0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      n = m_q.size();
      p = out_ready && (n > 0);
      if (p) void'(m_q.pop_front());
      if (memwrite) begin
        if (aluout[31:16] != 16'hFFFF) begin
          base = int'(aluout & 32'(NB - 1));
          if (byte_enable) m_mem[base] = writedata[7:0];
          else for (int k = 0; k < 4; k++) m_mem[(base & ~3) + k] = writedata[8*k +: 8];
        end else if (aluout == 32'hFFFF_0000) begin
          m_ovf = 1'b0;
        end else if (aluout == 32'hFFFF_0004) begin
          if (n < FD || p) m_q.push_back(writedata[7:0]);
          else m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic be);
    aluout = a; writedata = d; byte_enable = be; memwrite = 1'b1;
    step();
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic be, output logic [31:0] v);
    aluout = a; byte_enable = be; memwrite = 1'b0;
    #1;
    v = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0; memwrite = 1'b0; aluout = '0; writedata = '0;
    byte_enable = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    rd(32'hFFFF_0000, 1'b0, v); checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 00000002", v); end
    rd(32'h0000_0024, 1'b0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_ram: got %h want 0", v); end
  endtask

  task automatic test_ram_directed();
    logic [31:0] v;
    store(32'h10, 32'h1122_3344, 1'b0);
    store(32'h11, 32'h0000_00AA, 1'b1);
    rd(32'h10, 1'b0, v); checks++;
    if (v !== 32'h1122_AA44) begin errors++; $display("FAIL ram_lw: got %h want 1122aa44", v); end
    rd(32'h11, 1'b1, v); checks++;
    if (v !== 32'h0000_00AA) begin errors++; $display("FAIL ram_lb: got %h want 000000aa", v); end
    rd(32'h110, 1'b0, v); checks++;
    if (v !== 32'h1122_AA44) begin errors++; $display("FAIL ram_wrap: got %h want 1122aa44", v); end
  endtask

  task automatic test_ram_random();
    logic [31:0] a, v, e;
    logic be;
    for (int i = 0; i < 40; i++) begin
      a = $urandom();
      if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
      store(a, $urandom(), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 32'h3FF);
      be = 1'($urandom_range(0, 1));
      rd(a, be, v);
      e = m_read(a, be);
      checks++;
      if (v !== e) begin errors++; $display("FAIL ram_rand @%h be=%b: got %h want %h", a, be, v, e); end
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] v;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(32'hFFFF_0004, 32'h41 + 32'(i), 1'b0);
    rd(32'hFFFF_0000, 1'b0, v); checks++;
    if (v !== 32'h91) begin errors++; $display("FAIL ovf_status: got %h want 00000091", v); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h41 + i))
        begin errors++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 8'(8'h41 + i)); end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    rd(32'hFFFF_0000, 1'b0, v); checks++;
    if (v !== 32'h82) begin errors++; $display("FAIL drained_status: got %h want 00000082", v); end
  endtask

  task automatic test_ovf_clear();
    logic [31:0] v;
    store(32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0);
    rd(32'hFFFF_0000, 1'b0, v); checks++;
    if (v !== 32'h02) begin errors++; $display("FAIL ovf_clear: got %h want 00000002", v); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] v;
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h55};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'hFFFF_0004, 32'h10 + 32'(i), 1'b0);
    out_ready = 1'b1;
    store(32'hFFFF_0004, 32'h55, 1'b1);
    rd(32'hFFFF_0000, 1'b0, v); checks++;
    if (v !== 32'h11) begin errors++; $display("FAIL full_pushpop_status: got %h want 00000011", v); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i])
        begin errors++; $display("FAIL pushpop_seq[%0d]: got v=%b d=%h want %h", i, out_valid, out_data, exp_seq[i]); end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_fifo_random();
    logic [31:0] v, e;
    for (int i = 0; i < 80; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) store(32'hFFFF_0004, $urandom(), 1'($urandom_range(0, 1)));
      else step();
      checks++;
      if (out_valid !== (m_q.size() != 0) || (m_q.size() != 0 && out_data !== m_q[0]))
        begin errors++; $display("FAIL fifo_rand[%0d]: got v=%b d=%h want size=%0d", i, out_valid, out_data, m_q.size()); end
    end
    rd(32'hFFFF_0000, 1'b0, v);
    e = m_read(32'hFFFF_0000, 1'b0);
    checks++;
    if (v !== e) begin errors++; $display("FAIL fifo_rand_status: got %h want %h", v, e); end
    out_ready = 1'b1;
    repeat (FD + 1) step();
  endtask

  task automatic test_counter();
    logic [31:0] v, e;
    reset = 1'b0; step(); reset = 1'b1;
    repeat (10) step();
    rd(32'hFFFF_0008, 1'b0, v); checks++;
    if (v !== 32'd10) begin errors++; $display("FAIL cycle10: got %0d want 10", v); end
    store(32'hFFFF_0008, 32'h0, 1'b0);
    repeat (3) step();
    rd(32'hFFFF_0008, 1'b0, v);
    e = m_read(32'hFFFF_0008, 1'b0);
    checks++;
    if (v !== e) begin errors++; $display("FAIL cycle_store_ignored: got %0d want %0d", v, e); end
    rd(32'hFFFF_0020, 1'b0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL unmapped: got %h want 0", v); end
    rd(32'hFFFF_0004, 1'b0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL tx_read: got %h want 0", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    store(32'h0, 32'h1234_5678, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'hFFFF_0004, 32'h60 + 32'(i), 1'b0);
    aluout = 32'h0; writedata = 32'hDEAD_BEEF; byte_enable = 1'b0;
    memwrite = 1'b1; out_ready = 1'b1; reset = 1'b0;
    step();
    reset = 1'b1; memwrite = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    rd(32'hFFFF_0000, 1'b0, v); checks++;
    if (v !== 32'h02) begin errors++; $display("FAIL midrst_status: got %h want 00000002", v); end
    rd(32'h0, 1'b0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL midrst_ram: got %h want 0", v); end
  endtask

  initial begin
    test_reset();
    test_ram_directed();
    test_ram_random();
    test_fifo_overflow();
    test_ovf_clear();
    test_push_pop_full();
    test_fifo_random();
    test_counter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
